// File: rtl/sys_array2x2.sv
// 2x2 output-stationary systolic MAC array: A flows right, B flows down,
// each PE accumulates a K-term dot product and emits one saturated result.
module sys_array2x2 #(
  parameter int FRAC  = 8,
  parameter int ACC_W = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  max_cntr,
  output logic        aff0,
  output logic        aff1,
  output logic        bff0,
  output logic        bff1,
  input  logic [15:0] a_in0,
  input  logic [15:0] a_in1,
  input  logic [15:0] b_in0,
  input  logic [15:0] b_in1,
  input  logic        awe0,
  input  logic        awe1,
  input  logic        bwe0,
  input  logic        bwe1,
  output logic [15:0] s_out0_0,
  output logic [15:0] s_out0_1,
  output logic [15:0] s_out1_0,
  output logic [15:0] s_out1_1,
  output logic        sat0_0,
  output logic        sat0_1,
  output logic        sat1_0,
  output logic        sat1_1,
  output logic        sw0_0,
  output logic        sw0_1,
  output logic        sw1_0,
  output logic        sw1_1,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t      state;
  logic [7:0]  k_r;
  logic [7:0]  feed_cnt;
  logic        ff_q;

  logic [15:0] a1_sk, b1_sk;
  logic        a1v_sk, b1v_sk;
  logic [15:0] a_fw [2];
  logic [15:0] b_fw [2];
  logic        av_fw [2];
  logic        bv_fw [2];

  logic [15:0] pa  [2][2];
  logic [15:0] pb  [2][2];
  logic        pav [2][2];
  logic        pbv [2][2];

  logic [15:0] s_r   [4];
  logic        sat_r [4];
  logic        sw_r  [4];

  assign aff0 = ff_q;
  assign aff1 = ff_q;
  assign bff0 = ff_q;
  assign bff1 = ff_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      k_r      <= '0;
      feed_cnt <= '0;
      ff_q     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && max_cntr != '0) begin
            state    <= FEED;
            k_r      <= max_cntr;
            feed_cnt <= 8'd1;
            ff_q     <= 1'b1;
            busy     <= 1'b1;
          end
        end
        FEED: begin
          if (feed_cnt == k_r) begin
            ff_q  <= 1'b0;
            state <= DRAIN;
          end else begin
            feed_cnt <= feed_cnt + 8'd1;
          end
        end
        DRAIN: begin
          if (sw_r[3]) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Edge skew on row/column 1, plus the right/down forwarding registers.
  // Strobes are gated by busy so stray buffer output outside a run is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      a1_sk  <= '0;
      b1_sk  <= '0;
      a1v_sk <= 1'b0;
      b1v_sk <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        a_fw[i]  <= '0;
        b_fw[i]  <= '0;
        av_fw[i] <= 1'b0;
        bv_fw[i] <= 1'b0;
      end
    end else begin
      a1_sk  <= a_in1;
      b1_sk  <= b_in1;
      a1v_sk <= awe1 & busy;
      b1v_sk <= bwe1 & busy;
      for (int unsigned i = 0; i < 2; i++) begin
        a_fw[i]  <= pa[i][0];
        av_fw[i] <= pav[i][0];
        b_fw[i]  <= pb[0][i];
        bv_fw[i] <= pbv[0][i];
      end
    end
  end

  always_comb begin
    pa[0][0]  = a_in0;
    pav[0][0] = awe0 & busy;
    pa[1][0]  = a1_sk;
    pav[1][0] = a1v_sk;
    pb[0][0]  = b_in0;
    pbv[0][0] = bwe0 & busy;
    pb[0][1]  = b1_sk;
    pbv[0][1] = b1v_sk;
    for (int unsigned i = 0; i < 2; i++) begin
      pa[i][1]  = a_fw[i];
      pav[i][1] = av_fw[i];
      pb[1][i]  = b_fw[i];
      pbv[1][i] = bv_fw[i];
    end
  end

  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-32768);

  for (genvar i = 0; i < 2; i++) begin : g_row
    for (genvar j = 0; j < 2; j++) begin : g_col
      logic signed [ACC_W-1:0] acc, acc_nx, sh;
      logic signed [31:0]      prod;
      logic [7:0]              cnt;
      logic                    mac;
      logic [15:0]             s_q;
      logic                    sat_q, sw_q;

      always_comb begin
        mac    = pav[i][j] & pbv[i][j];
        prod   = $signed(pa[i][j]) * $signed(pb[i][j]);
        acc_nx = acc + {{(ACC_W-32){prod[31]}}, prod};
        sh     = acc_nx >>> FRAC;
      end

      // The final MAC is folded straight into the clamp so acc clears as the result registers.
      always_ff @(posedge clk) begin
        if (rst) begin
          acc   <= '0;
          cnt   <= '0;
          s_q   <= '0;
          sat_q <= 1'b0;
          sw_q  <= 1'b0;
        end else begin
          sw_q <= 1'b0;
          if (mac) begin
            if (8'(cnt + 8'd1) == k_r) begin
              acc  <= '0;
              cnt  <= '0;
              sw_q <= 1'b1;
              if (sh > SMAX) begin
                s_q   <= 16'h7FFF;
                sat_q <= 1'b1;
              end else if (sh < SMIN) begin
                s_q   <= 16'h8000;
                sat_q <= 1'b1;
              end else begin
                s_q   <= sh[15:0];
                sat_q <= 1'b0;
              end
            end else begin
              acc <= acc_nx;
              cnt <= cnt + 8'd1;
            end
          end
        end
      end

      assign s_r[i*2+j]   = s_q;
      assign sat_r[i*2+j] = sat_q;
      assign sw_r[i*2+j]  = sw_q;
    end
  end

  assign s_out0_0 = s_r[0];
  assign s_out0_1 = s_r[1];
  assign s_out1_0 = s_r[2];
  assign s_out1_1 = s_r[3];
  assign sat0_0   = sat_r[0];
  assign sat0_1   = sat_r[1];
  assign sat1_0   = sat_r[2];
  assign sat1_1   = sat_r[3];
  assign sw0_0    = sw_r[0];
  assign sw0_1    = sw_r[1];
  assign sw1_0    = sw_r[2];
  assign sw1_1    = sw_r[3];

endmodule
